// File: rtl/sec_counter_display_pkg.sv
// Shared definitions for the seconds counter / display block.
//   - state_t      : control FSM states
//   - SEG_*        : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   - DIG_W        : bits per BCD digit
//   - NUM_DIGITS   : number of displayed digits
//   - seg_encode() : BCD digit -> segment pattern
//   - bcd_inc()    : 4-digit BCD increment, returns {carry_out, value}
package sec_counter_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int DIG_W      = 4;
    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_encode(input logic [DIG_W-1:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Ripple carry from d0 upward; a carry out of d3 means 9999 -> 0000.
    function automatic logic [DIG_W*NUM_DIGITS:0] bcd_inc(
        input logic [DIG_W*NUM_DIGITS-1:0] v
    );
        logic [DIG_W*NUM_DIGITS-1:0] r;
        logic                        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                if (r[i*DIG_W +: DIG_W] == 4'd9) begin
                    r[i*DIG_W +: DIG_W] = 4'd0;
                end else begin
                    r[i*DIG_W +: DIG_W] = r[i*DIG_W +: DIG_W] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

endpackage

// File: rtl/sec_counter_display_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, then a debounce filter that
// samples only on pulse_filter ticks. The stable level flips after
// DEBOUNCE_N consecutive ticks that disagree with it. press pulses for one
// cycle, aligned with the stable level rising; release produces nothing.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   pulse_filter  one-cycle debounce sample tick
//   btn_raw       raw asynchronous button level
//   press         one-cycle press event
module sec_counter_display_btn_debounce #(
    parameter int DEBOUNCE_N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_filter,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_N + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        if (pulse_filter) begin
            if (sync2_q != stable_q) begin
                if (cnt_q + 1'b1 == CW'(DEBOUNCE_N)) begin
                    stable_d = ~stable_q;
                    cnt_d    = '0;
                    press_d  = ~stable_q;   // only the 0->1 flip is an event
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/sec_counter_display.sv
// 4-digit BCD seconds counter with start/stop and clear buttons and a
// multiplexed active-low 7-segment display.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   pulse_1s       count strobe (counts only in RUN)
//   pulse_filter   debounce sample tick
//   dig_sel        digit being displayed this cycle, 0 = ones
//   btn_start      raw start/stop button
//   btn_clr        raw clear button
//   seg, dp, an    registered display drive, all active-low
//   count_bcd      {d3,d2,d1,d0}
//   running        registered (state == RUN)
//   wrap           one-cycle pulse on 9999 -> 0000
module sec_counter_display
    import sec_counter_display_pkg::*;
#(
    parameter int DEBOUNCE_N    = 4,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pulse_1s,
    input  logic        pulse_filter,
    input  logic [1:0]  dig_sel,
    input  logic        btn_start,
    input  logic        btn_clr,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [15:0] count_bcd,
    output logic        running,
    output logic        wrap
);

    logic start_press, clr_press;

    sec_counter_display_btn_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_db_start (
        .clk          (clk),
        .rst          (rst),
        .pulse_filter (pulse_filter),
        .btn_raw      (btn_start),
        .press        (start_press)
    );

    sec_counter_display_btn_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_db_clr (
        .clk          (clk),
        .rst          (rst),
        .pulse_filter (pulse_filter),
        .btn_raw      (btn_clr),
        .press        (clr_press)
    );

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic        wrap_q, wrap_d;
    logic        running_q, running_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [3:0]  an_q, an_d;

    // Control and counting. Clear beats everything; in RUN the increment
    // is evaluated independently of a start press so both take effect.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr_press) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_press) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (pulse_1s) {wrap_d, count_d} = bcd_inc(count_q);
                    if (start_press) state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (start_press) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        running_d = (state_d == ST_RUN);
    end

    // Display path, one register stage from dig_sel/count.
    logic [15:0] upper;   // selected digit and everything above it
    logic [3:0]  digit;

    always_comb begin
        upper = count_q >> {dig_sel, 2'b00};
        digit = upper[DIG_W-1:0];
        an_d  = ~(4'b0001 << dig_sel);
        if (BLANK_LEADING && (dig_sel != 2'd0) && (upper == 16'h0000))
            seg_d = SEG_BLANK;
        else
            seg_d = seg_encode(digit);
        dp_d = ~((dig_sel == 2'd0) && (state_q == ST_PAUSE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            an_q      <= 4'hF;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign count_bcd = count_q;
    assign running   = running_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_sec_counter_display.sv
module tb_sec_counter_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        pulse_1s;
    logic        pulse_filter;
    logic [1:0]  dig_sel;
    logic        btn_start;
    logic        btn_clr;

    logic [6:0]  seg,  seg_nb;
    logic        dp,   dp_nb;
    logic [3:0]  an,   an_nb;
    logic [15:0] count_bcd, count_nb;
    logic        running, running_nb;
    logic        wrap, wrap_nb;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sec_counter_display #(.DEBOUNCE_N(4), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst(rst), .pulse_1s(pulse_1s), .pulse_filter(pulse_filter),
        .dig_sel(dig_sel), .btn_start(btn_start), .btn_clr(btn_clr),
        .seg(seg), .dp(dp), .an(an), .count_bcd(count_bcd),
        .running(running), .wrap(wrap)
    );

    // Same stimulus, leading-zero blanking disabled.
    sec_counter_display #(.DEBOUNCE_N(4), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .pulse_1s(pulse_1s), .pulse_filter(pulse_filter),
        .dig_sel(dig_sel), .btn_start(btn_start), .btn_clr(btn_clr),
        .seg(seg_nb), .dp(dp_nb), .an(an_nb), .count_bcd(count_nb),
        .running(running_nb), .wrap(wrap_nb)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ftick();
        pulse_filter = 1'b1;
        cyc();
        pulse_filter = 1'b0;
        cyc();
    endtask

    // Hold the chosen buttons through a full debounce, asserting pulse_1s
    // in the cycle the FSM sees the press event; then release and let the
    // filters settle back to 0.
    task automatic press(input logic s, input logic c, input logic ps);
        btn_start = s;
        btn_clr   = c;
        repeat (3) cyc();
        repeat (3) ftick();
        pulse_filter = 1'b1;
        cyc();
        pulse_filter = 1'b0;
        pulse_1s     = ps;
        cyc();
        pulse_1s  = 1'b0;
        btn_start = 1'b0;
        btn_clr   = 1'b0;
        repeat (3) cyc();
        repeat (4) ftick();
    endtask

    task automatic pulses(input int n);
        pulse_1s = 1'b1;
        repeat (n) cyc();
        pulse_1s = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; pulse_1s = 1'b0; pulse_filter = 1'b0;
        dig_sel = 2'd0; btn_start = 1'b0; btn_clr = 1'b0;
        repeat (2) cyc();

        // Reset values, checked while rst is still asserted.
        chk("rst_seg",     16'(seg),   16'h7F);
        chk("rst_dp",      16'(dp),    16'h1);
        chk("rst_an",      16'(an),    16'hF);
        chk("rst_count",   count_bcd,  16'h0000);
        chk("rst_running", 16'(running), 16'h0);
        chk("rst_wrap",    16'(wrap),  16'h0);
        rst = 1'b0;
        cyc();

        // Start press: running rises one cycle after the press event.
        btn_start = 1'b1;
        repeat (3) cyc();
        repeat (3) ftick();
        pulse_filter = 1'b1;
        cyc();
        pulse_filter = 1'b0;
        chk("start_event_running", 16'(running), 16'h0);
        cyc();
        chk("start_after_running", 16'(running), 16'h1);
        btn_start = 1'b0;
        repeat (3) cyc();
        repeat (4) ftick();
        pulses(3);
        chk("count3", count_bcd, 16'h0003);

        // Bouncing button: alternating samples never reach 4 in a row.
        for (int i = 0; i < 10; i++) begin
            btn_start = ~btn_start;
            ftick();
        end
        btn_start = 1'b0;
        repeat (3) cyc();
        repeat (4) ftick();
        chk("bounce_running", 16'(running), 16'h1);
        chk("bounce_count",   count_bcd,    16'h0003);

        // Rollover.
        pulses(6);
        chk("count9", count_bcd, 16'h0009);
        pulses(9990);
        chk("count9999", count_bcd, 16'h9999);
        chk("pre_wrap",  16'(wrap),  16'h0);
        pulse_1s = 1'b1;
        cyc();
        pulse_1s = 1'b0;
        chk("wrap_count",   count_bcd,      16'h0000);
        chk("wrap_pulse",   16'(wrap),      16'h1);
        chk("wrap_running", 16'(running),   16'h1);
        cyc();
        chk("wrap_oneshot", 16'(wrap),      16'h0);

        // Pause / resume.
        pulses(42);
        chk("count42", count_bcd, 16'h0042);
        press(1'b1, 1'b0, 1'b0);
        chk("pause_running", 16'(running), 16'h0);
        pulses(5);
        chk("pause_count", count_bcd, 16'h0042);
        chk("pause_dp",    16'(dp),   16'h0);
        chk("pause_an",    16'(an),   16'hE);
        chk("pause_seg",   16'(seg),  16'h24);
        press(1'b1, 1'b0, 1'b0);
        chk("resume_running", 16'(running), 16'h1);
        chk("resume_dp",      16'(dp),      16'h1);

        // Clear + start + pulse in RUN: clear wins.
        press(1'b1, 1'b1, 1'b1);
        chk("clr_all_count",   count_bcd,    16'h0000);
        chk("clr_all_running", 16'(running), 16'h0);
        chk("clr_all_wrap",    16'(wrap),    16'h0);
        press(1'b1, 1'b0, 1'b0);
        chk("idle_to_run", 16'(running), 16'h1);
        // Start + pulse in RUN: increment, then PAUSE.
        press(1'b1, 1'b0, 1'b1);
        chk("start_pulse_count",   count_bcd,    16'h0001);
        chk("start_pulse_running", 16'(running), 16'h0);
        // PAUSE + start + pulse: no increment, back to RUN.
        press(1'b1, 1'b0, 1'b1);
        chk("resume_pulse_count",   count_bcd,    16'h0001);
        chk("resume_pulse_running", 16'(running), 16'h1);
        dig_sel = 2'd1;
        cyc();
        chk("blank_d1_seg",    16'(seg),    16'h7F);
        chk("noblank_d1_seg",  16'(seg_nb), 16'h40);
        chk("blank_d1_an",     16'(an),     16'hD);
        dig_sel = 2'd0;

        // Display sweep at 0105.
        press(1'b0, 1'b1, 1'b0);
        chk("clr_count", count_bcd, 16'h0000);
        press(1'b1, 1'b0, 1'b0);
        pulses(105);
        chk("count105", count_bcd, 16'h0105);
        dig_sel = 2'd0; cyc();
        chk("d0_an", 16'(an), 16'hE);  chk("d0_seg", 16'(seg), 16'h12);
        chk("d0_dp", 16'(dp), 16'h1);
        dig_sel = 2'd1; cyc();
        chk("d1_an", 16'(an), 16'hD);  chk("d1_seg", 16'(seg), 16'h40);
        dig_sel = 2'd2; cyc();
        chk("d2_an", 16'(an), 16'hB);  chk("d2_seg", 16'(seg), 16'h79);
        dig_sel = 2'd3; cyc();
        chk("d3_an", 16'(an), 16'h7);  chk("d3_seg", 16'(seg), 16'h7F);
        chk("d3_seg_noblank", 16'(seg_nb), 16'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
